des_key_schedule: RTL and testbench

- Generates the 16 DES round subkeys (48 bits each) from a 64-bit key, one subkey per handshake, in encrypt order (K1..K16) or decrypt order (K16..K1).
- Sits directly upstream of the DES round function and drives its 48-bit `key_dat` input.
- Holds each subkey until the round controller accepts it, so round pacing is set downstream.

---
 rtl/des_pkg.sv | 40 ++++
 rtl/des_pc2.sv | 19 +
 rtl/des_key_schedule.sv | 143 ++++++++++++++
 tb/tb_des_key_schedule.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES constants: key-schedule permutation tables, rotate schedule and
// the key-schedule state encoding. Table entries use DES 1-based bit numbers.
package des_pkg;

    localparam int NUM_ROUNDS = 16;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Left-rotate amount applied to C and D to reach round 1..16.
    localparam logic [1:0] SHIFT [NUM_ROUNDS] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

endpackage

// File: rtl/des_pc2.sv
// DES Permuted Choice 2: compresses the 56-bit C/D pair to a 48-bit subkey.
// Bit 55 of i_cd is C bit 1; bit 47 of o_subkey is PC-2 output bit 1.
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] i_cd,
    output logic [47:0] o_subkey
);

    for (genvar g = 0; g < 48; g++) begin : g_pc2
        assign o_subkey[47-g] = i_cd[56-PC2[g]];
    end

    // DES bits 9,18,22,25,35,38,43,54 are dropped by PC-2.
    logic w_unused_dropped;
    assign w_unused_dropped = ^{i_cd[47], i_cd[38], i_cd[34], i_cd[31],
                                i_cd[21], i_cd[18], i_cd[13], i_cd[2]};

endmodule

// File: rtl/des_key_schedule.sv
// DES subkey generator: emits K1..K16 (or K16..K1) one per valid/ready
// transfer, holding each subkey until the downstream round logic accepts it.
module des_key_schedule
    import des_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_decrypt,
    input  logic [63:0] i_key_in,
    output logic        o_ready,
    output logic [47:0] o_subkey,
    output logic        o_subkey_valid,
    input  logic        i_subkey_ready,
    output logic [3:0]  o_round_idx,
    output logic        o_done
);

    state_e      r_state;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic [47:0] r_subkey;
    logic [3:0]  r_idx;
    logic        r_decrypt;
    logic        r_done;

    logic [55:0] w_pc1;
    logic [27:0] w_pc1_c;
    logic [27:0] w_pc1_d;
    logic        w_two;
    logic [27:0] w_c_rot;
    logic [27:0] w_d_rot;
    logic [27:0] w_c_next;
    logic [27:0] w_d_next;
    logic [47:0] w_subkey_next;
    logic        w_load;
    logic        w_xfer;

    for (genvar g = 0; g < 56; g++) begin : g_pc1
        assign w_pc1[55-g] = i_key_in[64-PC1[g]];
    end
    assign w_pc1_c = w_pc1[55:28];
    assign w_pc1_d = w_pc1[27:0];

    // Parity bits (DES bits 8,16,..,64) play no part in the schedule.
    logic w_unused_parity;
    assign w_unused_parity = ^{i_key_in[56], i_key_in[48], i_key_in[40], i_key_in[32],
                               i_key_in[24], i_key_in[16], i_key_in[8],  i_key_in[0]};

    // Encrypt moves C_i -> C_(i+1) by SHIFT of round i+1; decrypt undoes the
    // shift that produced the current round, walking back from C16 = C0.
    always_comb begin
        w_two = 1'b0;
        if (r_decrypt)
            w_two = (SHIFT[4'd15 - r_idx] == 2'd2);
        else
            w_two = (SHIFT[r_idx + 4'd1] == 2'd2);
    end

    always_comb begin
        w_c_rot = r_c;
        w_d_rot = r_d;
        case ({r_decrypt, w_two})
            2'b00: begin
                w_c_rot = {r_c[26:0], r_c[27]};
                w_d_rot = {r_d[26:0], r_d[27]};
            end
            2'b01: begin
                w_c_rot = {r_c[25:0], r_c[27:26]};
                w_d_rot = {r_d[25:0], r_d[27:26]};
            end
            2'b10: begin
                w_c_rot = {r_c[0], r_c[27:1]};
                w_d_rot = {r_d[0], r_d[27:1]};
            end
            default: begin
                w_c_rot = {r_c[1:0], r_c[27:2]};
                w_d_rot = {r_d[1:0], r_d[27:2]};
            end
        endcase
    end

    assign w_load = (r_state == IDLE) && i_start;
    assign w_xfer = (r_state == EMIT) && i_subkey_ready;

    always_comb begin
        w_c_next = w_c_rot;
        w_d_next = w_d_rot;
        if (r_state == IDLE) begin
            if (i_decrypt) begin
                w_c_next = w_pc1_c;
                w_d_next = w_pc1_d;
            end else begin
                w_c_next = {w_pc1_c[26:0], w_pc1_c[27]};
                w_d_next = {w_pc1_d[26:0], w_pc1_d[27]};
            end
        end
    end

    des_pc2 u_pc2 (
        .i_cd     ({w_c_next, w_d_next}),
        .o_subkey (w_subkey_next)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_c       <= '0;
            r_d       <= '0;
            r_subkey  <= '0;
            r_idx     <= '0;
            r_decrypt <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_state   <= EMIT;
                r_decrypt <= i_decrypt;
                r_c       <= w_c_next;
                r_d       <= w_d_next;
                r_subkey  <= w_subkey_next;
                r_idx     <= '0;
            end else if (w_xfer) begin
                if (r_idx == 4'(NUM_ROUNDS - 1)) begin
                    r_state <= IDLE;
                    r_done  <= 1'b1;
                end else begin
                    r_idx    <= r_idx + 4'd1;
                    r_c      <= w_c_next;
                    r_d      <= w_d_next;
                    r_subkey <= w_subkey_next;
                end
            end
        end
    end

    assign o_ready        = (r_state == IDLE);
    assign o_subkey_valid = (r_state == EMIT);
    assign o_subkey       = r_subkey;
    assign o_round_idx    = r_idx;
    assign o_done         = r_done;

endmodule

// File: tb/tb_des_key_schedule.sv
// Randomised bench for des_key_schedule against a cumulative-rotation DES
// key-schedule model, plus literal subkeys from the classic worked example.
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst_n, start, decrypt, subkey_ready;
    logic [63:0] key_in;
    logic        ready, subkey_valid, done;
    logic [47:0] subkey;
    logic [3:0]  round_idx;

    always #5 clk = ~clk;

    des_key_schedule dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .i_decrypt      (decrypt),
        .i_key_in       (key_in),
        .o_ready        (ready),
        .o_subkey       (subkey),
        .o_subkey_valid (subkey_valid),
        .i_subkey_ready (subkey_ready),
        .o_round_idx    (round_idx),
        .o_done         (done)
    );

    localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
    localparam logic [47:0] K1  = 48'h1B02EFFC7072;
    localparam logic [47:0] K2  = 48'h79AED9DBC9E5;
    localparam logic [47:0] K16 = 48'hCB3D8B0E17F5;

    int tb_pc1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                        10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                        63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                        14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    int tb_pc2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10,
                        23,19,12,4,26,8, 16,7,27,20,13,2,
                        41,52,31,37,47,55, 30,40,51,45,33,48,
                        44,49,39,56,34,53, 46,42,50,36,29,32};
    int tb_sh [16]  = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    int n_tests = 0;
    int n_fail  = 0;

    logic [47:0] mk [16];
    logic [47:0] m_q [$];
    logic [47:0] log_q [$];
    logic [47:0] enc_log [16];
    int          m_idx = 0;
    bit          m_done = 0, m_zero = 0, m_armed = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
        logic [55:0] w;
        w = {x, x};
        return w[55-n -: 28];
    endfunction

    // Subkey i uses C0/D0 rotated left by the running total of shifts 1..i.
    task automatic compute(input logic [63:0] k);
        logic [27:0] c0, d0;
        logic [55:0] cd;
        int rot;
        rot = 0;
        for (int j = 1; j <= 28; j++) begin
            c0[28-j] = k[64-tb_pc1[j-1]];
            d0[28-j] = k[64-tb_pc1[j+27]];
        end
        for (int r = 0; r < 16; r++) begin
            rot += tb_sh[r];
            cd = {rotl28(c0, rot), rotl28(d0, rot)};
            for (int i = 1; i <= 48; i++) mk[r][48-i] = cd[56-tb_pc2[i-1]];
        end
    endtask

    // Model/compare process: check at negedge, advance the model at posedge.
    initial begin
        bit nd;
        forever begin
            @(negedge clk);
            if (m_armed) begin
                chk("ready", ready, m_q.size() == 0);
                chk("subkey_valid", subkey_valid, m_q.size() != 0);
                chk("done", done, m_done);
                if (m_q.size() != 0) begin
                    chk("subkey", subkey, m_q[0]);
                    chk("round_idx", round_idx, m_idx);
                end else if (m_zero) begin
                    chk("subkey_reset", subkey, 0);
                end
                if (subkey_valid && subkey_ready) log_q.push_back(subkey);
            end
            @(posedge clk);
            if (!rst_n) begin
                m_armed = 1;
                m_q.delete();
                m_idx  = 0;
                m_done = 0;
                m_zero = 1;
            end else if (m_armed) begin
                nd = 0;
                if (m_q.size() == 0) begin
                    if (start) begin
                        compute(key_in);
                        for (int r = 0; r < 16; r++) m_q.push_back(decrypt ? mk[15-r] : mk[r]);
                        m_idx  = 0;
                        m_zero = 0;
                    end
                end else if (subkey_ready) begin
                    void'(m_q.pop_front());
                    m_idx++;
                    if (m_q.size() == 0) nd = 1;
                end
                m_done = nd;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [63:0] k, input logic d);
        key_in  = k;
        decrypt = d;
        start   = 1'b1;
        cyc();
        start   = 1'b0;
        key_in  = {$urandom, $urandom};
        decrypt = 1'($urandom);
    endtask

    task automatic run(input int duty, input int limit);
        int n;
        n = 0;
        while (1) begin
            subkey_ready = ($urandom_range(0, 99) < duty);
            cyc();
            if (done) break;
            n++;
            if (n > limit) begin
                n_tests++;
                n_fail++;
                $display("FAIL timeout: no done after %0d cycles", limit);
                break;
            end
        end
        subkey_ready = 1'b0;
    endtask

    task automatic chk_log_enc(input string name);
        chk({name, "_len"}, log_q.size(), 16);
        if (log_q.size() == 16)
            for (int i = 0; i < 16; i++) chk(name, log_q[i], enc_log[i]);
    endtask

    initial begin
        logic [63:0] rk;
        rst_n = 1'b0; start = 1'b0; decrypt = 1'b0; subkey_ready = 1'b0; key_in = '0;

        compute(KEY);
        chk("model_k1", mk[0], K1);
        chk("model_k2", mk[1], K2);
        chk("model_k16", mk[15], K16);

        cyc(); cyc();
        rst_n = 1'b1;
        cyc();

        // Encrypt, full throughput
        log_q.delete();
        go(KEY, 1'b0);
        run(100, 40);
        chk("enc_len", log_q.size(), 16);
        if (log_q.size() == 16) begin
            chk("enc_first", log_q[0], K1);
            chk("enc_second", log_q[1], K2);
            chk("enc_last", log_q[15], K16);
            for (int i = 0; i < 16; i++) enc_log[i] = log_q[i];
        end

        // Decrypt must be the exact reverse
        log_q.delete();
        go(KEY, 1'b1);
        run(100, 40);
        chk("dec_len", log_q.size(), 16);
        if (log_q.size() == 16) begin
            chk("dec_first", log_q[0], K16);
            chk("dec_second_last", log_q[14], K2);
            chk("dec_last", log_q[15], K1);
            for (int i = 0; i < 16; i++) chk("dec_reverse", log_q[i], enc_log[15-i]);
        end

        // Backpressure at 30% duty
        log_q.delete();
        go(KEY, 1'b0);
        run(30, 2000);
        chk_log_enc("bp_seq");

        // Random keys and directions under backpressure
        for (int t = 0; t < 4; t++) begin
            rk = {$urandom, $urandom};
            go(rk, 1'($urandom));
            run(30, 2000);
        end

        // start with another key at round_idx 7 is ignored
        log_q.delete();
        go(KEY, 1'b0);
        subkey_ready = 1'b1;
        repeat (7) cyc();
        chk("mid_idx7", round_idx, 7);
        key_in = 64'hFEDCBA9876543210;
        decrypt = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        run(100, 40);
        chk_log_enc("mid_start");

        // Reset at round_idx 9
        go(KEY, 1'b0);
        subkey_ready = 1'b1;
        repeat (9) cyc();
        chk("rst_idx9", round_idx, 9);
        rst_n = 1'b0;
        subkey_ready = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("rst_valid", subkey_valid, 0);
        chk("rst_subkey", subkey, 0);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        cyc();
        log_q.delete();
        go(KEY, 1'b0);
        run(100, 40);
        chk("post_rst_len", log_q.size(), 16);
        if (log_q.size() > 0) chk("post_rst_k1", log_q[0], K1);

        // Back-to-back: all-zero key then all-one key, one idle cycle between
        log_q.delete();
        go(64'h0, 1'b0);
        subkey_ready = 1'b1;
        repeat (16) cyc();
        chk("b2b_done", done, 1);
        chk("b2b_ready", ready, 1);
        go(64'hFFFFFFFFFFFFFFFF, 1'b0);
        chk("b2b_restart_valid", subkey_valid, 1);
        run(100, 40);
        chk("b2b_len", log_q.size(), 32);
        if (log_q.size() == 32)
            for (int i = 0; i < 32; i++)
                chk("b2b_val", log_q[i], (i < 16) ? 48'h0 : 48'hFFFFFFFFFFFF);

        cyc(); cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
